// File: rtl/goal_vote_fsm.sv
// rtl/goal_vote_fsm.sv - multi-cycle referee goal vote with saturating per-team scores
module goal_vote_fsm #(
    parameter int N_REF   = 3,
    parameter int SCORE_W = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               claim,
    input  logic               claim_team,
    input  logic [N_REF-1:0]   vote_valid,
    input  logic [N_REF-1:0]   vote_yes,
    output logic               busy,
    output logic               decided,
    output logic               goal,
    output logic               goal_team,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b
);
    localparam int                 PC_W      = $clog2(N_REF + 1);
    localparam logic [PC_W:0]      MAJ_LIMIT = (PC_W + 1)'(N_REF);
    localparam logic [7:0]         TMO_LAST  = 8'(TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DECIDE
    } state_t;

    state_t           state;
    logic [N_REF-1:0] voted;
    logic [N_REF-1:0] yes;
    logic [N_REF-1:0] fresh;
    logic [N_REF-1:0] voted_nxt;
    logic [N_REF-1:0] yes_nxt;
    logic [7:0]       tmo_cnt;
    logic [PC_W-1:0]  yes_cnt;
    logic             all_voted;
    logic             timed_out;
    logic             majority;

    // Decision looks at the votes including those arriving this cycle;
    // only a referee's first strobe in the window is taken.
    always_comb begin
        fresh     = vote_valid & ~voted;
        voted_nxt = voted | fresh;
        yes_nxt   = yes | (fresh & vote_yes);
        yes_cnt   = '0;
        for (int i = 0; i < N_REF; i++) begin
            yes_cnt = yes_cnt + PC_W'(yes_nxt[i]);
        end
        all_voted = &voted_nxt;
        timed_out = (tmo_cnt == TMO_LAST);
        majority  = ({yes_cnt, 1'b0} > MAJ_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            decided   <= 1'b0;
            goal      <= 1'b0;
            goal_team <= 1'b0;
            score_a   <= '0;
            score_b   <= '0;
            voted     <= '0;
            yes       <= '0;
            tmo_cnt   <= '0;
        end else begin
            decided <= 1'b0;
            goal    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (claim) begin
                        state     <= COLLECT;
                        busy      <= 1'b1;
                        goal_team <= claim_team;
                        voted     <= '0;
                        yes       <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    voted   <= voted_nxt;
                    yes     <= yes_nxt;
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (all_voted || timed_out) begin
                        state   <= DECIDE;
                        decided <= 1'b1;
                        goal    <= majority;
                    end
                end
                DECIDE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    // goal is the registered verdict held during this cycle
                    if (goal) begin
                        if (!goal_team) begin
                            if (score_a != SCORE_MAX) score_a <= score_a + SCORE_ONE;
                        end else begin
                            if (score_b != SCORE_MAX) score_b <= score_b + SCORE_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_goal_vote_fsm.sv
// tb/tb_goal_vote_fsm.sv - vector table, corner sequences and random model check of goal_vote_fsm
module tb_goal_vote_fsm;
    localparam int N_REF   = 3;
    localparam int SCORE_W = 2;
    localparam int TIMEOUT = 15;
    localparam int SMAX    = (1 << SCORE_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               claim;
    logic               claim_team;
    logic [N_REF-1:0]   vote_valid;
    logic [N_REF-1:0]   vote_yes;
    logic               busy;
    logic               decided;
    logic               goal;
    logic               goal_team;
    logic [SCORE_W-1:0] score_a;
    logic [SCORE_W-1:0] score_b;

    int n_checks = 0;
    int n_fail   = 0;
    int sa       = 0;
    int sb       = 0;

    always #5 clk = ~clk;

    goal_vote_fsm #(.N_REF(N_REF), .SCORE_W(SCORE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .claim(claim), .claim_team(claim_team),
        .vote_valid(vote_valid), .vote_yes(vote_yes), .busy(busy),
        .decided(decided), .goal(goal), .goal_team(goal_team),
        .score_a(score_a), .score_b(score_b)
    );

    typedef struct {
        bit       team;
        bit [2:0] yes;
        bit       exp_goal;
        int       exp_a;
        int       exp_b;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit c, input bit t, input logic [2:0] v, input logic [2:0] y);
        claim      = c;
        claim_team = t;
        vote_valid = v;
        vote_yes   = y;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 3'b000, 3'b000);
        tick();
        tick();
        rst = 1'b0;
        sa  = 0;
        sb  = 0;
        chk("reset_busy", busy, 0);
        chk("reset_decided", decided, 0);
        chk("reset_scores", {score_a, score_b}, 0);
        chk("reset_goal_team", goal_team, 0);
    endtask

    // Transaction-level model: each referee's first vote lands at an offset
    // into the window; the window closes when the last referee votes or at timeout.
    task automatic rand_txn();
        int       off[N_REF];
        bit       val[N_REF];
        int       maxoff;
        int       win;
        int       cnt;
        int       gap;
        bit       t;
        bit       eg;
        bit [2:0] v;
        bit [2:0] y;
        t      = 1'($urandom_range(0, 1));
        maxoff = 0;
        for (int i = 0; i < N_REF; i++) begin
            off[i] = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 4);
            val[i] = 1'($urandom_range(0, 1));
            if (off[i] > maxoff) maxoff = off[i];
        end
        win = (maxoff + 1 < TIMEOUT) ? maxoff + 1 : TIMEOUT;
        cnt = 0;
        for (int i = 0; i < N_REF; i++) if (off[i] < win && val[i]) cnt++;
        eg  = (2 * cnt > N_REF);

        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
            drive(0, 1'($urandom), 3'($urandom), 3'($urandom));
            tick();
            chk("rnd_idle_busy", busy, 0);
            chk("rnd_idle_decided", decided, 0);
        end
        drive(1, t, 3'($urandom), 3'($urandom));
        tick();
        chk("rnd_claim_busy", busy, 1);
        chk("rnd_claim_team", goal_team, t);
        for (int k = 0; k < win; k++) begin
            for (int i = 0; i < N_REF; i++) begin
                if (off[i] == k) begin
                    v[i] = 1'b1;
                    y[i] = val[i];
                end else if (off[i] < k) begin
                    v[i] = 1'($urandom);
                    y[i] = 1'($urandom);
                end else begin
                    v[i] = 1'b0;
                    y[i] = 1'($urandom);
                end
            end
            drive(1'($urandom), ~t, v, y);
            tick();
            chk("rnd_busy", busy, 1);
            if (k < win - 1) begin
                chk("rnd_early_decided", decided, 0);
            end else begin
                chk("rnd_decided", decided, 1);
                chk("rnd_goal", goal, eg);
            end
        end
        if (eg) begin
            if (t) sb = (sb < SMAX) ? sb + 1 : SMAX;
            else   sa = (sa < SMAX) ? sa + 1 : SMAX;
        end
        drive(1'($urandom), ~t, 3'($urandom), 3'($urandom));
        tick();
        chk("rnd_post_decided", decided, 0);
        chk("rnd_post_goal", goal, 0);
        chk("rnd_post_busy", busy, 0);
        chk("rnd_score_a", score_a, sa);
        chk("rnd_score_b", score_b, sb);
        chk("rnd_goal_team_hold", goal_team, t);
    endtask

    initial begin
        vecs[0] = '{0, 3'b011, 1, 1, 0};
        vecs[1] = '{0, 3'b000, 0, 1, 0};
        vecs[2] = '{1, 3'b111, 1, 1, 1};
        vecs[3] = '{1, 3'b001, 0, 1, 1};
        vecs[4] = '{0, 3'b110, 1, 2, 1};
        vecs[5] = '{0, 3'b101, 1, 3, 1};
        vecs[6] = '{0, 3'b111, 1, 3, 1};
        vecs[7] = '{1, 3'b010, 0, 3, 1};
        vecs[8] = '{1, 3'b100, 0, 3, 1};
        vecs[9] = '{1, 3'b011, 1, 3, 2};

        do_reset();

        // all votes in first COLLECT cycle: decided at claim+2, score at claim+3
        foreach (vecs[n]) begin
            drive(1, vecs[n].team, 3'b000, 3'b000);
            tick();
            chk("tbl_busy", busy, 1);
            drive(0, 0, 3'b111, vecs[n].yes);
            tick();
            chk("tbl_decided", decided, 1);
            chk("tbl_goal", goal, vecs[n].exp_goal);
            drive(0, 0, 3'b000, 3'b000);
            tick();
            chk("tbl_post_decided", decided, 0);
            chk("tbl_post_busy", busy, 0);
            chk("tbl_score_a", score_a, vecs[n].exp_a);
            chk("tbl_score_b", score_b, vecs[n].exp_b);
            chk("tbl_goal_team", goal_team, vecs[n].team);
        end

        // team B, votes on separate cycles: 1, 0, 0
        do_reset();
        drive(1, 1, 3'b000, 3'b000); tick();
        drive(0, 0, 3'b001, 3'b001); tick(); chk("sep_dec0", decided, 0);
        drive(0, 0, 3'b010, 3'b000); tick(); chk("sep_dec1", decided, 0);
        drive(0, 0, 3'b100, 3'b000); tick();
        chk("sep_decided", decided, 1);
        chk("sep_goal", goal, 0);
        chk("sep_busy_in_decide", busy, 1);
        drive(0, 0, 3'b000, 3'b000); tick();
        chk("sep_busy_drop", busy, 0);
        chk("sep_scores", {score_a, score_b}, 0);
        chk("sep_goal_team", goal_team, 1);

        // timeout: only referee 0 votes yes, later re-votes no
        do_reset();
        drive(1, 0, 3'b000, 3'b000); tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            if (k == 0)      drive(0, 0, 3'b001, 3'b001);
            else if (k == 1) drive(0, 0, 3'b001, 3'b000);
            else             drive(0, 0, 3'b000, 3'b000);
            tick();
            if (k == TIMEOUT - 2) chk("tmo_not_yet", decided, 0);
            if (k == TIMEOUT - 1) begin
                chk("tmo_decided", decided, 1);
                chk("tmo_goal", goal, 0);
            end
        end
        drive(0, 0, 3'b000, 3'b000); tick();
        chk("tmo_busy", busy, 0);
        chk("tmo_scores", {score_a, score_b}, 0);

        // duplicate votes: ref1 yes twice, ref2 no, ref0 yes
        do_reset();
        drive(1, 0, 3'b000, 3'b000); tick();
        drive(0, 0, 3'b010, 3'b010); tick();
        drive(0, 0, 3'b110, 3'b010); tick(); chk("dup_dec_early", decided, 0);
        drive(0, 0, 3'b001, 3'b001); tick();
        chk("dup_decided", decided, 1);
        chk("dup_goal", goal, 1);
        drive(0, 0, 3'b000, 3'b000); tick();
        chk("dup_score_a", score_a, 1);

        // first vote wins: ref0 no then yes, ref1 yes, ref2 no -> 1 of 3
        drive(1, 0, 3'b000, 3'b000); tick();
        drive(0, 0, 3'b011, 3'b010); tick();
        drive(0, 0, 3'b011, 3'b011); tick(); chk("fvw_dec_early", decided, 0);
        drive(0, 0, 3'b100, 3'b000); tick();
        chk("fvw_decided", decided, 1);
        chk("fvw_goal", goal, 0);
        drive(0, 0, 3'b000, 3'b000); tick();
        chk("fvw_score_a", score_a, 1);

        // saturation of team B at 3
        do_reset();
        for (int g = 0; g < 4; g++) begin
            drive(1, 1, 3'b000, 3'b000); tick();
            drive(0, 0, 3'b111, 3'b111); tick();
            chk("sat_goal", goal, 1);
            drive(0, 0, 3'b000, 3'b000); tick();
            chk("sat_score_b", score_b, (g + 1 > SMAX) ? SMAX : g + 1);
        end

        // reset mid-COLLECT with two yes votes latched
        do_reset();
        drive(1, 0, 3'b000, 3'b000); tick();
        drive(0, 0, 3'b011, 3'b011); tick();
        chk("mid_still_collect", busy, 1);
        rst = 1'b1;
        drive(1, 1, 3'b100, 3'b100); tick();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_decided", decided, 0);
        chk("mid_rst_scores", {score_a, score_b}, 0);
        chk("mid_rst_goal_team", goal_team, 0);
        rst = 1'b0;
        drive(1, 1, 3'b100, 3'b100); tick();
        chk("mid_claim_busy", busy, 1);
        chk("mid_claim_team", goal_team, 1);
        drive(0, 0, 3'b011, 3'b011); tick();
        chk("mid_idle_vote_ignored", decided, 0);
        drive(0, 0, 3'b100, 3'b000); tick();
        chk("mid_decided", decided, 1);
        chk("mid_goal", goal, 1);
        drive(0, 0, 3'b000, 3'b000); tick();
        chk("mid_score_b", score_b, 1);
        chk("mid_score_a", score_a, 0);

        do_reset();
        for (int r = 0; r < 200; r++) begin
            if ($urandom_range(0, 24) == 0) do_reset();
            rand_txn();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/goal_vote_fsm.md
# goal_vote_fsm

Sequential, parametrised goal-decision block for the soccer logic. Generalises the 3-input combinational goal vote: a claim opens a voting window, N_REF referees vote over several cycles, a strict majority awards the goal, and per-team scores accumulate. It sits between the referee input capture and the scoreboard display logic.

## Interface
- N_REF, 3: number of referees; odd, 1..15
- SCORE_W, 4: score counter width per team
- TIMEOUT, 15: max COLLECT cycles before forced decision; 1..255
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- claim  in  1  goal claim request; accepted only in IDLE
- claim_team  in  1  team claimed for (0 = A, 1 = B); sampled with accepted claim
- vote_valid  in  N_REF  per-referee vote strobe
- vote_yes  in  N_REF  per-referee vote value (1 = goal), qualified by vote_valid
- busy  out  1  high in COLLECT and DECIDE
- decided  out  1  one-cycle pulse: decision made
- goal  out  1  one-cycle pulse with decided when majority yes
- goal_team  out  1  team of current/last decision
- score_a  out  SCORE_W  team A score
- score_b  out  SCORE_W  team B score

## Operation
- States: IDLE, COLLECT, DECIDE.
- IDLE: claim=1 -> latch claim_team into goal_team, clear voted/yes registers, clear timeout counter, go COLLECT. vote_valid ignored in IDLE.
- COLLECT: per referee i, if vote_valid[i] and voted[i]==0, set voted[i]=1, yes[i]=vote_yes[i]. Repeat votes from a referee already voted are ignored (first vote wins). claim ignored.
- COLLECT exit: next state DECIDE when all voted bits (including votes captured this cycle) are 1, or when timeout counter reaches TIMEOUT-1 (i.e. after TIMEOUT COLLECT cycles). Both true same cycle -> DECIDE, same result.
- Missing votes at timeout count as no.
- DECIDE (exactly one cycle): decided=1; goal=1 iff 2*popcount(yes) > N_REF. If goal, increment score of goal_team at end of cycle, saturating at 2^SCORE_W-1 (no wrap). Next state IDLE unconditionally.
- popcount width: clog2(N_REF+1) bits; compare without truncation.
- goal_team holds last claimed team until next accepted claim.

## Timing
- Reset (any state, including mid-COLLECT/DECIDE): state=IDLE, busy=0, decided=0, goal=0, goal_team=0, score_a=0, score_b=0, voted/yes/timeout cleared. Pending vote discarded; no score change.
- claim accepted at edge t -> busy=1 from t+1.
- Earliest decision: all votes present in first COLLECT cycle (t+1) -> decided/goal at t+2, score updated visible at t+3, busy=0 and IDLE at t+3.
- Timeout: decided at t+1+TIMEOUT.
- claim asserted in DECIDE cycle is ignored; new claim accepted from the first IDLE cycle onward.
- decided and goal are registered outputs of DECIDE state (no combinational path from inputs).

## Test plan
- Reset then claim(team A), votes 1,1,0 all in first COLLECT cycle -> decided=goal=1 at cycle claim+2, score_a=1 next cycle, score_b=0.
- Claim(team B), votes 1 then 0 then 0 on separate cycles -> decided=1, goal=0, scores unchanged, busy drops cycle after DECIDE.
- Claim(team A), only referee 0 votes yes, TIMEOUT=15 -> decided at claim+16, goal=0 (1 of 3); referee 0 re-vote with vote_yes=0 ignored.
- Duplicate-vote check: referee 1 votes yes twice, referee 2 no, referee 0 yes -> goal=1; second strobe does not double-count.
- Saturation: SCORE_W=2, four consecutive unanimous team-B goals -> score_b 1,2,3,3.
- rst asserted mid-COLLECT with 2 yes votes latched -> next cycle IDLE, busy=0, no decided pulse, scores 0; claim ignored during reset cycle, accepted after.
